// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one shift + trial subtract per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds one sign-fix cycle).
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int unsigned PW    = WIDTH + 1;
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef DIV_SIGNED_EN
    , FIX
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  // Upper bit of the partial remainder is always zero between steps, so only WIDTH bits are kept.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             busy_r;

  logic [PW-1:0]    shifted;
  logic [PW-1:0]    trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dq;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;
  assign dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  // One restoring step: shift in next dividend bit, subtract as a + ~b + 1.
  always_comb begin
    shifted = {rem, dq[WIDTH-1]};
    trial   = shifted + ~{1'b0, dvs} + PW'(1);
    if (!trial[WIDTH]) begin
      step_rem = trial[WIDTH-1:0];
      step_dq  = {dq[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shifted[WIDTH-1:0];
      step_dq  = {dq[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dq         <= dvd_mag;
            dvs        <= dvs_mag;
            rem        <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
`ifdef DIV_SIGNED_EN
            q_neg      <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg      <= bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= step_rem;
          dq  <= step_dq;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
            state <= FIX;
`else
            quotient_r  <= step_dq;
            remainder_r <= step_rem;
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        FIX: begin
          quotient_r  <= q_neg ? (~dq + WIDTH'(1)) : dq;
          remainder_r <= r_neg ? (~rem + WIDTH'(1)) : rem;
          dbz_r       <= 1'b0;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider at WIDTH=4.
module tb_seq_restoring_divider;

  localparam int unsigned WIDTH = 4;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid (bounded); busy_ok drops if busy/in_ready misbehave meanwhile.
  task automatic wait_result(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r, output logic d);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == 4'd0) begin
      q = 4'hF; r = a; d = 1'b1;
    end else begin
      d = 1'b0;
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -8 && sb == -1) begin
        q = 4'h8; r = 4'h0;
      end else begin
        q = 4'(sa / sb);
        r = 4'(sa % sb);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.quotient !== 4'h0 || bus.remainder !== 4'h0 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b q=%h r=%h dbz=%b, need 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    logic busy_ok;
`ifdef DIV_SIGNED_EN
    logic [3:0] a_t [2] = '{4'h9, 4'h8};
    logic [3:0] b_t [2] = '{4'h2, 4'hF};
    logic [3:0] q_t [2] = '{4'hD, 4'h8};
    logic [3:0] r_t [2] = '{4'hF, 4'h0};
    for (int i = 0; i < 2; i++) begin
`else
    logic [3:0] a_t [4] = '{4'd13, 4'd15, 4'd3, 4'd15};
    logic [3:0] b_t [4] = '{4'd4,  4'd1,  4'd7, 4'd15};
    logic [3:0] q_t [4] = '{4'd3,  4'd15, 4'd0, 4'd1};
    logic [3:0] r_t [4] = '{4'd1,  4'd0,  4'd3, 4'd0};
    for (int i = 0; i < 4; i++) begin
`endif
      start_op(a_t[i], b_t[i]);
      wait_result(lat, busy_ok);
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL basic_latency %0d/%0d: got %0d edges, need %0d", a_t[i], b_t[i], lat, LAT);
      end
      vectors++;
      if (bus.quotient !== q_t[i] || bus.remainder !== r_t[i] || bus.div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_result %h/%h: q=%h r=%h dbz=%b, need q=%h r=%h dbz=0",
                 a_t[i], b_t[i], bus.quotient, bus.remainder, bus.div_by_zero, q_t[i], r_t[i]);
      end
      vectors++;
      if (busy_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_busy %h/%h: busy low or in_ready high during operation", a_t[i], b_t[i]);
      end
      drain();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic busy_ok;
    start_op(4'd5, 4'd0);
    wait_result(lat, busy_ok);
    vectors++;
    if (lat !== 0) begin
      miscompares++;
      $display("FAIL dbz_latency: got %0d edges, need 0", lat);
    end
    vectors++;
    if (bus.quotient !== 4'hF || bus.remainder !== 4'h5 || bus.div_by_zero !== 1'b1 || busy_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL dbz_result: q=%h r=%h dbz=%b busy_ok=%b, need q=f r=5 dbz=1 busy_ok=1",
               bus.quotient, bus.remainder, bus.div_by_zero, busy_ok);
    end
    drain();
  endtask

  task automatic test_stall();
    int lat;
    logic busy_ok;
`ifdef DIV_SIGNED_EN
    logic [3:0] eq = 4'hD;
    logic [3:0] er = 4'hF;
`else
    logic [3:0] eq = 4'd4;
    logic [3:0] er = 4'd1;
`endif
    start_op(4'd9, 4'd2);
    bus.in_valid = 1'b1;
    bus.dividend = 4'd15;
    bus.divisor  = 4'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat, busy_ok);
    vectors++;
    if (lat !== LAT - 1) begin
      miscompares++;
      $display("FAIL stall_latency: got %0d further edges, need %0d", lat, LAT - 1);
    end
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: q=%h r=%h vld=%b rdy=%b, need q=%h r=%h vld=1 rdy=0",
                 c, bus.quotient, bus.remainder, bus.out_valid, bus.in_ready, eq, er);
      end
      @(posedge clk); #1;
    end
    drain();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.quotient !== eq || bus.remainder !== er) begin
      miscompares++;
      $display("FAIL stall_release: vld=%b rdy=%b busy=%b q=%h r=%h, need 0 1 0 q=%h r=%h",
               bus.out_valid, bus.in_ready, bus.busy, bus.quotient, bus.remainder, eq, er);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic busy_ok;
`ifdef DIV_SIGNED_EN
    logic [3:0] eq = 4'hF;
    logic [3:0] er = 4'hE;
`else
    logic [3:0] eq = 4'd3;
    logic [3:0] er = 4'd2;
`endif
    start_op(4'd11, 4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.quotient !== 4'h0 || bus.remainder !== 4'h0 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: rdy=%b vld=%b busy=%b q=%h r=%h dbz=%b, need 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(4'd11, 4'd3);
    wait_result(lat, busy_ok);
    vectors++;
    if (lat !== LAT || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_retry: lat=%0d q=%h r=%h dbz=%b, need lat=%0d q=%h r=%h dbz=0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero, LAT, eq, er);
    end
    drain();
  endtask

  task automatic test_exhaustive();
    int lat;
    logic busy_ok;
    logic [7:0] iv;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eq;
    logic [3:0] er;
    logic ed;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      a  = iv[7:4];
      b  = iv[3:0];
      model(a, b, eq, er, ed);
      start_op(a, b);
      wait_result(lat, busy_ok);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      vectors++;
      if (lat !== (ed ? 0 : LAT) || bus.out_valid !== 1'b1 || bus.quotient !== eq ||
          bus.remainder !== er || bus.div_by_zero !== ed) begin
        miscompares++;
        $display("FAIL exhaustive %h/%h: lat=%0d vld=%b q=%h r=%h dbz=%b, need lat=%0d vld=1 q=%h r=%h dbz=%b",
                 a, b, lat, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero,
                 ed ? 0 : LAT, eq, er, ed);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_stall();
    test_reset_mid_run();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
